servo_position_sequencer: RTL and testbench

SERVO_POSITION_SEQUENCER -- requirements
Module: servo_position_sequencer

---
 rtl/servo_position_sequencer.sv | 179 +++++++++++++++++
 tb/tb_servo_position_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_position_sequencer.sv
// Servo position sequencer: debounced step/mode keys drive a four-position
// cycle that changes only on servo frame boundaries, manually or on a dwell.
module servo_position_sequencer #(
    parameter int DEBOUNCE_CLKS = 500000,
    parameter int FRAME_CLKS    = 1000000,
    parameter int DWELL_FRAMES  = 50
) (
    input  logic       d_in_clk,
    input  logic       d_reset,
    input  logic       d_enable,
    input  logic       d_key_step,
    input  logic       d_key_mode,
    output logic [7:0] d_duty_cycle,
    output logic       d_frame_tick,
    output logic       d_auto_mode
);

    localparam int DBW = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;
    localparam int FCW = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;
    localparam int DWW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CLKS - 1);
    localparam logic [FCW-1:0] FR_LAST = FCW'(FRAME_CLKS - 1);
    localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        CENTRE_A,
        MINUS90,
        CENTRE_B,
        PLUS90
    } pos_t;

    // bit 0 = step key, bit 1 = mode key
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     acc;
    logic [1:0]     db_hit;
    logic [DBW-1:0] db_cnt [2];
    logic           step_press;
    logic           mode_press;

    logic [FCW-1:0] frame_cnt;

    pos_t           state;
    pos_t           state_n;
    logic           pending;
    logic           pending_n;
    logic [DWW-1:0] dwell;
    logic [DWW-1:0] dwell_n;
    logic           auto_n;

    function automatic pos_t next_pos(input pos_t s);
        next_pos = CENTRE_A;
        unique case (s)
            CENTRE_A: next_pos = MINUS90;
            MINUS90:  next_pos = CENTRE_B;
            CENTRE_B: next_pos = PLUS90;
            PLUS90:   next_pos = CENTRE_A;
        endcase
    endfunction

    function automatic logic [7:0] code_of(input pos_t s);
        code_of = 8'd0;
        unique case (s)
            CENTRE_A: code_of = 8'd0;
            MINUS90:  code_of = 8'd1;
            CENTRE_B: code_of = 8'd0;
            PLUS90:   code_of = 8'd2;
        endcase
    endfunction

    // Two-flop synchronizers for the raw, idle-high pushbuttons
    always_ff @(posedge d_in_clk or negedge d_reset) begin
        if (!d_reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {d_key_mode, d_key_step};
            sync2 <= sync1;
        end
    end

    // A level is accepted once it has differed for DEBOUNCE_CLKS clocks
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            db_hit[k] = (sync2[k] != acc[k]) && (db_cnt[k] == DB_LAST);
        end
    end

    // Press = accepted level about to fall from 1 to 0
    assign step_press = db_hit[0] & acc[0];
    assign mode_press = db_hit[1] & acc[1];

    // Per-key stability counters and accepted levels
    always_ff @(posedge d_in_clk or negedge d_reset) begin
        if (!d_reset) begin
            acc <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == acc[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_hit[k]) begin
                    acc[k]    <= sync2[k];
                    db_cnt[k] <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + DBW'(1);
                end
            end
        end
    end

    // Frame counter; tick follows the last enabled count of a frame
    always_ff @(posedge d_in_clk or negedge d_reset) begin
        if (!d_reset) begin
            frame_cnt    <= '0;
            d_frame_tick <= 1'b0;
        end else begin
            d_frame_tick <= d_enable && (frame_cnt == FR_LAST);
            if (d_enable) begin
                if (frame_cnt == FR_LAST) begin
                    frame_cnt <= '0;
                end else begin
                    frame_cnt <= frame_cnt + FCW'(1);
                end
            end
        end
    end

    // Next position, pending, dwell and mode; a mode press overrides a tick
    always_comb begin
        state_n   = state;
        pending_n = pending;
        dwell_n   = dwell;
        auto_n    = d_auto_mode;
        if (mode_press) begin
            auto_n    = ~d_auto_mode;
            dwell_n   = '0;
            pending_n = 1'b0;
        end else if (d_auto_mode) begin
            pending_n = 1'b0;
            if (d_frame_tick) begin
                if (dwell == DW_LAST) begin
                    state_n = next_pos(state);
                    dwell_n = '0;
                end else begin
                    dwell_n = dwell + DWW'(1);
                end
            end
        end else if (d_frame_tick) begin
            if (pending || step_press) begin
                state_n = next_pos(state);
            end
            pending_n = 1'b0;
        end else if (step_press) begin
            pending_n = 1'b1;
        end
    end

    // Position state and registered outputs
    always_ff @(posedge d_in_clk or negedge d_reset) begin
        if (!d_reset) begin
            state        <= CENTRE_A;
            pending      <= 1'b0;
            dwell        <= '0;
            d_auto_mode  <= 1'b0;
            d_duty_cycle <= 8'd0;
        end else begin
            state        <= state_n;
            pending      <= pending_n;
            dwell        <= dwell_n;
            d_auto_mode  <= auto_n;
            d_duty_cycle <= code_of(state_n);
        end
    end

endmodule

// File: tb/tb_servo_position_sequencer.sv
// Bench for servo_position_sequencer: cycle model compared every negedge,
// plus directed manual, glitch, auto, pause and reset scenarios.
module tb_servo_position_sequencer;

    localparam int D  = 4;
    localparam int F  = 10;
    localparam int DW = 3;

    logic       d_in_clk = 1'b0;
    logic       d_reset;
    logic       d_enable;
    logic       d_key_step;
    logic       d_key_mode;
    logic [7:0] d_duty_cycle;
    logic       d_frame_tick;
    logic       d_auto_mode;

    int n_checks = 0;
    int n_fail   = 0;

    servo_position_sequencer #(
        .DEBOUNCE_CLKS(D),
        .FRAME_CLKS   (F),
        .DWELL_FRAMES (DW)
    ) dut (
        .d_in_clk    (d_in_clk),
        .d_reset     (d_reset),
        .d_enable    (d_enable),
        .d_key_step  (d_key_step),
        .d_key_mode  (d_key_mode),
        .d_duty_cycle(d_duty_cycle),
        .d_frame_tick(d_frame_tick),
        .d_auto_mode (d_auto_mode)
    );

    always #5 d_in_clk = ~d_in_clk;

    // ---------------- model ----------------
    bit hs [D+2];
    bit hm [D+2];
    bit m_acc_s = 1'b1;
    bit m_acc_m = 1'b1;
    bit m_tick  = 1'b0;
    bit m_auto  = 1'b0;
    bit m_pend  = 1'b0;
    int m_fc    = 0;
    int m_dwell = 0;
    int m_pos   = 0;

    initial begin
        for (int i = 0; i < D + 2; i++) begin
            hs[i] = 1'b1;
            hm[i] = 1'b1;
        end
    end

    // position 0..3 cycles centre, -90, centre, +90
    function automatic int code_of(input int p);
        return (p == 1) ? 1 : (p == 3) ? 2 : 0;
    endfunction

    always @(posedge d_in_clk or negedge d_reset) begin
        bit old_tick, sp, mp, lo_s, hi_s, lo_m, hi_m;
        if (!d_reset) begin
            for (int i = 0; i < D + 2; i++) begin
                hs[i] = 1'b1;
                hm[i] = 1'b1;
            end
            m_acc_s = 1'b1;
            m_acc_m = 1'b1;
            m_tick  = 1'b0;
            m_auto  = 1'b0;
            m_pend  = 1'b0;
            m_fc    = 0;
            m_dwell = 0;
            m_pos   = 0;
        end else begin
            old_tick = m_tick;
            for (int i = 0; i < D + 1; i++) begin
                hs[i] = hs[i+1];
                hm[i] = hm[i+1];
            end
            hs[D+1] = d_key_step;
            hm[D+1] = d_key_mode;
            // window = samples 2..D+1 edges old, as seen past the synchronizer
            lo_s = 1; hi_s = 1; lo_m = 1; hi_m = 1;
            for (int i = 0; i < D; i++) begin
                if (hs[i]) lo_s = 0; else hi_s = 0;
                if (hm[i]) lo_m = 0; else hi_m = 0;
            end
            sp = m_acc_s && lo_s;
            mp = m_acc_m && lo_m;
            if (m_acc_s && lo_s) m_acc_s = 0;
            else if (!m_acc_s && hi_s) m_acc_s = 1;
            if (m_acc_m && lo_m) m_acc_m = 0;
            else if (!m_acc_m && hi_m) m_acc_m = 1;

            m_tick = d_enable && (m_fc == F - 1);
            if (d_enable) m_fc = (m_fc + 1) % F;

            if (mp) begin
                m_auto  = !m_auto;
                m_dwell = 0;
                m_pend  = 0;
            end else if (m_auto) begin
                m_pend = 0;
                if (old_tick) begin
                    m_dwell = m_dwell + 1;
                    if (m_dwell == DW) begin
                        m_dwell = 0;
                        m_pos   = (m_pos + 1) % 4;
                    end
                end
            end else if (old_tick) begin
                if (m_pend || sp) m_pos = (m_pos + 1) % 4;
                m_pend = 0;
            end else if (sp) begin
                m_pend = 1;
            end
        end
    end

    // Every-cycle comparison of outputs against the model
    always @(negedge d_in_clk) begin
        n_checks += 3;
        if (int'(d_duty_cycle) != code_of(m_pos)) begin
            n_fail++;
            $display("FAIL model_duty t=%0t: got %0d, expected %0d",
                     $time, d_duty_cycle, code_of(m_pos));
        end
        if (d_frame_tick !== m_tick) begin
            n_fail++;
            $display("FAIL model_tick t=%0t: got %0b, expected %0b",
                     $time, d_frame_tick, m_tick);
        end
        if (d_auto_mode !== m_auto) begin
            n_fail++;
            $display("FAIL model_auto t=%0t: got %0b, expected %0b",
                     $time, d_auto_mode, m_auto);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step_neg();
        @(negedge d_in_clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step_neg();
            n++;
        end while (!d_frame_tick && n < 40);
        if (!d_frame_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: got no tick, expected one within 40");
        end
    endtask

    task automatic press(input int key, input int n_low, input int settle);
        if (key == 0) d_key_step = 1'b0;
        else          d_key_mode = 1'b0;
        repeat (n_low) step_neg();
        d_key_step = 1'b1;
        d_key_mode = 1'b1;
        repeat (settle) step_neg();
    endtask

    int exp_seq [13] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 2, 2, 2, 0};

    initial begin
        int n;
        int seen;
        d_reset    = 1'b0;
        d_enable   = 1'b0;
        d_key_step = 1'b1;
        d_key_mode = 1'b1;
        repeat (3) step_neg();
        chk("reset_duty", int'(d_duty_cycle), 0);
        chk("reset_tick", int'(d_frame_tick), 0);
        chk("reset_auto", int'(d_auto_mode), 0);

        d_reset  = 1'b1;
        d_enable = 1'b1;
        wait_tick(n);
        chk("first_tick", n, 10);
        wait_tick(n);
        chk("tick_period", n, 10);
        wait_tick(n);
        chk("tick_period2", n, 10);
        chk("idle_duty", int'(d_duty_cycle), 0);

        // three presses inside one (frozen) frame -> one advance
        step_neg();
        d_enable = 1'b0;
        repeat (3) press(0, 8, 8);
        d_enable = 1'b1;
        wait_tick(n);
        step_neg();
        chk("manual_adv", int'(d_duty_cycle), 1);
        wait_tick(n);
        step_neg();
        chk("manual_once", int'(d_duty_cycle), 1);

        d_enable = 1'b0;
        press(0, 8, 8);
        d_enable = 1'b1;
        wait_tick(n);
        step_neg();
        chk("manual_2", int'(d_duty_cycle), 0);

        d_enable = 1'b0;
        press(0, 8, 8);
        d_enable = 1'b1;
        wait_tick(n);
        step_neg();
        chk("manual_3", int'(d_duty_cycle), 2);

        // short glitch must not register
        d_enable = 1'b0;
        press(0, 2, 8);
        d_enable = 1'b1;
        wait_tick(n);
        step_neg();
        chk("glitch_a", int'(d_duty_cycle), 2);
        wait_tick(n);
        step_neg();
        chk("glitch_b", int'(d_duty_cycle), 2);

        d_enable = 1'b0;
        press(0, 8, 8);
        d_enable = 1'b1;
        wait_tick(n);
        step_neg();
        chk("manual_4", int'(d_duty_cycle), 0);

        // auto sweep
        d_enable = 1'b0;
        press(1, 8, 8);
        chk("auto_on", int'(d_auto_mode), 1);
        d_enable = 1'b1;
        for (int k = 0; k < 13; k++) begin
            wait_tick(n);
            chk($sformatf("auto_seq%0d", k), int'(d_duty_cycle), exp_seq[k]);
            if (k == 4) press(0, 8, 0);
        end

        // pause mid-frame, mid-dwell
        wait_tick(n);
        chk("pre_pause_tick", n, 10);
        repeat (4) step_neg();
        d_enable = 1'b0;
        seen = 0;
        repeat (25) begin
            step_neg();
            if (d_frame_tick) seen++;
        end
        chk("pause_no_tick", seen, 0);
        d_enable = 1'b1;
        wait_tick(n);
        chk("pause_resume", n, 6);
        step_neg();
        chk("dwell_resume", int'(d_duty_cycle), 1);

        // back to manual, set pending, then reset pulse
        d_enable = 1'b0;
        press(1, 8, 8);
        chk("auto_off", int'(d_auto_mode), 0);
        press(0, 8, 8);
        chk("pre_reset_duty", int'(d_duty_cycle), 1);
        d_reset = 1'b0;
        #1;
        chk("async_reset_duty", int'(d_duty_cycle), 0);
        chk("async_reset_auto", int'(d_auto_mode), 0);
        step_neg();
        d_reset  = 1'b1;
        d_enable = 1'b1;
        wait_tick(n);
        chk("reset_first_tick", n, 10);
        step_neg();
        chk("reset_no_adv", int'(d_duty_cycle), 0);

        repeat (5) step_neg();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end before 200000");
        $fatal(1, "watchdog");
    end

endmodule
